program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Writer side of the CPU program-memory byte-write port (pmWrEn/pm_addr/instructionIn).
//  Accepts 32-bit instruction words over a valid/ready stream and splits each word into four byte writes.
//  Byte writes go to consecutive addresses, little-endian: byte k of word n is written to addr 4n+k.
//  Holds the CPU in reset while loading and reports completion or overflow.
// PARAMETERS
//  ADD_WIDTH   7   program-memory byte address width; memory holds 2**ADD_WIDTH bytes (32 words at default)
//  DATA_WIDTH  32  instruction word width; fixed at 4 bytes
// PORTS
//  clk        in   1             clock, rising edge
//  rst        in   1             asynchronous, active-low reset
//  start      in   1             1-cycle pulse: begin load session at address 0
//  s_valid    in   1             instruction word valid
//  s_ready    out  1             loader can accept a word
//  s_data     in   32            instruction word
//  s_last     in   1             qualifies s_data as final word of the program
//  pm_wr_en   out  1             byte write strobe -> CPU pmWrEn
//  pm_addr    out  ADD_WIDTH     byte write address -> CPU pm_addr
//  pm_data    out  8             byte write data -> CPU instructionIn
//  cpu_hold   out  1             active-high hold; integration maps it to the CPU reset
//  busy       out  1             session in progress (LOAD or WRITE)
//  done       out  1             1-cycle pulse: program loaded successfully
//  overflow   out  1             sticky: words exceeded memory capacity
//  word_cnt   out  ADD_WIDTH-1   words fully written this session
// BEHAVIOUR
//  Reset values
//  - state=IDLE; s_ready, pm_wr_en, busy, done, overflow = 0; pm_addr, pm_data, word_cnt = 0; cpu_hold = 1.
//  - Reset is honoured mid-operation: any partial word is abandoned.
//  FSM states: IDLE, LOAD, WRITE, DONE, ERR.
//  IDLE
//  - start -> LOAD. On entry: addr=0, word_cnt=0, overflow=0, cpu_hold=1.
//  LOAD
//  - s_ready=1, registered and asserted in-state.
//  - On s_valid & s_ready: latch s_data and s_last, byte_idx=0, -> WRITE.
//  WRITE (exactly 4 cycles)
//  - pm_wr_en=1, pm_addr=addr, pm_data=word[8*byte_idx+:8]. Each cycle: addr++, byte_idx++. s_ready=0.
//  - On byte_idx==3:
//    - word_cnt++.
//    - If latched last -> DONE.
//    - Else if addr was the top byte (2**ADD_WIDTH-1) -> ERR.
//    - Else -> LOAD.
//  DONE
//  - done=1 for one cycle; cpu_hold=0 (registered, stays 0); -> IDLE.
//  ERR
//  - overflow=1, cpu_hold=1, s_ready=0. Stays until start (-> LOAD, flags cleared) or reset.
//  Timing
//  - Handshake in cycle N -> byte writes on cycles N+1..N+4 -> s_ready again at N+5.
//  - Throughput: 1 word per 5 cycles.
//  Boundary conditions
//  - start ignored in LOAD/WRITE/DONE; honoured in IDLE and ERR.
//  - s_last on word 2**(ADD_WIDTH-2) (memory exactly full) -> DONE, no overflow.
//  - addr wraps to 0 only on the DONE path; never written past the top on the ERR path.
//  - s_valid while s_ready=0 is held by the source; the word is not lost.
//  - busy = (state==LOAD)|(state==WRITE).
//  - pm_wr_en is never asserted outside WRITE.
// TESTING
//  1 Reset: hold rst=0 -> cpu_hold=1, pm_wr_en=0, s_ready=0; release with no start -> outputs unchanged.
//  2 start; send 0x00A00093, then 0x12345678 with last
//    -> bytes 93,00,A0,00,78,56,34,12 at addr 0..7.
//    -> done pulse 1 cycle; word_cnt=2; cpu_hold=0.
//  3 Backpressure: s_valid held high with 3 back-to-back words -> s_ready pattern 1,0,0,0,0,1; no byte skipped or duplicated.
//  4 32 words with last on word 32 -> addr 0..127 written; done=1; overflow=0.
//    33 words, no last before 33 -> ERR after word 32; overflow=1; s_ready=0; no write at addr 0.
//  5 Disturbances:
//    - rst=0 asserted during the 2nd byte write -> all outputs return to reset values asynchronously.
//    - start pulsed during WRITE -> ignored; session completes normally.
//  6 From ERR, pulse start -> overflow=0, word_cnt=0, reload of 1 word lands at addr 0..3.

Source files
------------

// File: rtl/program_loader.sv
// Writer side of the CPU program-memory byte port: splits 32-bit words from a
// valid/ready stream into four little-endian byte writes, holding the CPU meanwhile.
//   state | meaning
//   IDLE  | waiting for start, CPU released after a good load
//   LOAD  | s_ready high, waiting for the next word
//   WRITE | four byte-write cycles for the latched word
//   DONE  | one-cycle done pulse, CPU released
//   ERR   | memory full without s_last; sticky overflow until start
module program_loader #(
    parameter int ADD_WIDTH  = 7,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_last_i,
    output logic                  pm_wr_en_o,
    output logic [ADD_WIDTH-1:0]  pm_addr_o,
    output logic [7:0]            pm_data_o,
    output logic                  cpu_hold_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  overflow_o,
    output logic [ADD_WIDTH-2:0]  word_cnt_o
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] ERR   = 3'd4;

    localparam logic [ADD_WIDTH-1:0] ADDR_TOP = '1;

    logic [2:0]            state_q, state_d;
    logic [ADD_WIDTH-1:0]  addr_q, addr_d;
    logic [1:0]            idx_q, idx_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  last_q, last_d;
    logic [ADD_WIDTH-2:0]  cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  hold_q, hold_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        word_d  = word_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE, ERR: begin
                if (start_i) begin
                    state_d = LOAD;
                    addr_d  = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    hold_d  = 1'b1;
                end
            end
            LOAD: begin
                if (s_valid_i && ready_q) begin
                    word_d  = s_data_i;
                    last_d  = s_last_i;
                    idx_d   = 2'd0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_q) begin
                        state_d = DONE;
                        addr_d  = addr_q + 1'b1;
                        hold_d  = 1'b0;
                    end else if (addr_q == ADDR_TOP) begin
                        // keep the address pinned at the top; it only wraps on a completed load
                        state_d = ERR;
                        ovf_d   = 1'b1;
                        hold_d  = 1'b1;
                    end else begin
                        state_d = LOAD;
                        addr_d  = addr_q + 1'b1;
                    end
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == LOAD);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            idx_q   <= 2'd0;
            word_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            hold_q  <= 1'b1;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            hold_q  <= hold_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign s_ready_o  = ready_q;
    assign pm_wr_en_o = (state_q == WRITE);
    assign pm_addr_o  = addr_q;
    assign pm_data_o  = word_q[{idx_q, 3'b000} +: 8];
    assign cpu_hold_o = hold_q;
    assign busy_o     = (state_q == LOAD) || (state_q == WRITE);
    assign done_o     = done_q;
    assign overflow_o = ovf_q;
    assign word_cnt_o = cnt_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: the stimulus side predicts every byte write
// from the word index, a monitor pops and compares each write the DUT makes.
module tb_program_loader;

    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [31:0]   s_data = '0;
    logic          s_last = 1'b0;
    logic          pm_wr_en;
    logic [AW-1:0] pm_addr;
    logic [7:0]    pm_data;
    logic          cpu_hold, busy, done, overflow;
    logic [AW-2:0] word_cnt;

    int vectors = 0;
    int miscompares = 0;
    int model_words = 0;
    logic [AW+7:0] exp_q[$];

    program_loader #(.ADD_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data), .s_last_i(s_last),
        .pm_wr_en_o(pm_wr_en), .pm_addr_o(pm_addr), .pm_data_o(pm_data),
        .cpu_hold_o(cpu_hold), .busy_o(busy), .done_o(done),
        .overflow_o(overflow), .word_cnt_o(word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every byte write must match the oldest prediction
    always @(negedge clk) begin
        if (rst_n && pm_wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {17'd0, pm_addr, pm_data}, 32'hFFFF_FFFF);
            end else begin
                check("byte_write", {17'd0, pm_addr, pm_data}, {17'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic pulse_start();
        model_words = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] data, input logic last, input int gap,
                             output int waits);
        bit ok;
        logic [AW-1:0] a;
        logic [7:0] b;
        s_valid = 1'b1;
        s_data  = data;
        s_last  = last;
        waits   = 0;
        ok      = 1'b1;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            waits++;
            if (waits > 30) begin
                check("ready_timeout", 32'd0, 32'd1);
                ok = 1'b0;
                break;
            end
        end
        if (ok) begin
            for (int k = 0; k < 4; k++) begin
                a = AW'((4 * model_words + k) % (1 << AW));
                b = 8'((data >> (8 * k)) & 32'hFF);
                exp_q.push_back({a, b});
            end
            model_words++;
        end
        @(posedge clk); #1;
        if (gap > 0) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic end_stream();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic finish_session(input int n);
        int t;
        t = 0;
        forever begin
            @(negedge clk);
            if (done || t > 40) break;
            t++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        check("word_cnt", {26'd0, word_cnt}, 32'(n));
        check("cpu_hold_released", {31'd0, cpu_hold}, 32'd0);
        check("no_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("hold_stays_low", {31'd0, cpu_hold}, 32'd0);
        check("idle_not_busy", {31'd0, busy}, 32'd0);
        check("all_bytes_written", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
        check({tag, "_pm_wr_en"}, {31'd0, pm_wr_en}, 32'd0);
        check({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
        check({tag, "_pm_addr"}, {25'd0, pm_addr}, 32'd0);
        check({tag, "_pm_data"}, {24'd0, pm_data}, 32'd0);
        check({tag, "_word_cnt"}, {26'd0, word_cnt}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w, t, rdy_cnt, n;

        // reset held, then released with no start
        repeat (2) @(negedge clk);
        check_reset_outputs("rst_hold");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_release");
        @(posedge clk); #1;

        // two fixed words
        pulse_start();
        send_word(32'h00A0_0093, 1'b0, 1, w);
        send_word(32'h1234_5678, 1'b1, 0, w);
        end_stream();
        finish_session(2);

        // back-to-back words with s_valid held high
        pulse_start();
        send_word($urandom, 1'b0, 0, w);
        send_word($urandom, 1'b0, 0, w);
        check("backpressure_gap1", 32'(w), 32'd4);
        send_word($urandom, 1'b1, 0, w);
        check("backpressure_gap2", 32'(w), 32'd4);
        end_stream();
        finish_session(3);

        // exactly full memory
        pulse_start();
        for (int i = 0; i < 32; i++) send_word($urandom, (i == 31), $urandom_range(0, 2), w);
        end_stream();
        finish_session(32);

        // one word too many
        pulse_start();
        for (int i = 0; i < 32; i++) send_word($urandom, 1'b0, $urandom_range(0, 1), w);
        s_valid = 1'b1;
        s_data  = $urandom;
        s_last  = 1'b0;
        t = 0;
        forever begin
            @(negedge clk);
            if (overflow || t > 40) break;
            t++;
        end
        check("overflow_set", {31'd0, overflow}, 32'd1);
        check("overflow_word_cnt", {26'd0, word_cnt}, 32'd32);
        check("overflow_hold", {31'd0, cpu_hold}, 32'd1);
        check("overflow_not_busy", {31'd0, busy}, 32'd0);
        rdy_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (s_ready) rdy_cnt++;
        end
        check("err_no_ready", 32'(rdy_cnt), 32'd0);
        check("err_overflow_sticky", {31'd0, overflow}, 32'd1);
        @(posedge clk); #1;
        end_stream();

        // restart from ERR
        pulse_start();
        @(negedge clk);
        check("restart_overflow_clr", {31'd0, overflow}, 32'd0);
        check("restart_word_cnt_clr", {26'd0, word_cnt}, 32'd0);
        check("restart_ready", {31'd0, s_ready}, 32'd1);
        @(posedge clk); #1;
        send_word($urandom, 1'b1, 0, w);
        end_stream();
        finish_session(1);

        // asynchronous reset during the second byte write
        pulse_start();
        send_word(32'hCAFE_F00D, 1'b0, 1, w);
        check("pre_rst_wr_en", {31'd0, pm_wr_en}, 32'd1);
        check("pre_rst_addr", {25'd0, pm_addr}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_idle", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // start pulse while writing is ignored
        pulse_start();
        send_word($urandom, 1'b0, 0, w);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send_word($urandom, 1'b1, 0, w);
        end_stream();
        finish_session(2);

        // random sessions
        for (int s = 0; s < 4; s++) begin
            pulse_start();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) send_word($urandom, (i == n - 1), $urandom_range(0, 3), w);
            end_stream();
            finish_session(n);
        end

        repeat (3) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
